// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: PC control, instruction-memory handshake, decode
// handshake, redirect/halt controls and the retired-instruction count.
interface fetch_sequencer_if #(
  parameter int unsigned COUNT_W = 32
);
  logic [31:0]        pc_q;
  logic [1:0]         PS;
  logic [29:0]        pc_in;
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [31:0]        imem_rdata;
  logic               inst_valid;
  logic [31:0]        inst_data;
  logic               inst_ready;
  logic               branch_req;
  logic [29:0]        branch_offset;
  logic               jump_req;
  logic [29:0]        jump_target;
  logic               trap_req;
  logic               halt_req;
  logic               halted;
  logic [COUNT_W-1:0] inst_count;

  // Sequencer side.
  modport slave (
    input  pc_q, imem_ack, imem_rdata, inst_ready,
           branch_req, branch_offset, jump_req, jump_target, trap_req, halt_req,
    output PS, pc_in, imem_req, imem_addr, inst_valid, inst_data, halted, inst_count
  );

  // Environment side: PC register, instruction memory, decode, redirect sources.
  modport master (
    output pc_q, imem_ack, imem_rdata, inst_ready,
           branch_req, branch_offset, jump_req, jump_target, trap_req, halt_req,
    input  PS, pc_in, imem_req, imem_addr, inst_valid, inst_data, halted, inst_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch control FSM: drives PC select/operand, a single-outstanding
// imem request, the decode valid/ready handshake and an accepted-instruction count.
module fetch_sequencer #(
  parameter logic [29:0] TRAP_VECTOR = 30'h00000100,
  parameter int unsigned COUNT_W     = 32
) (
  input logic             clock,
  input logic             reset,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic               inst_valid_q, inst_valid_d;
  logic [31:0]        inst_data_q, inst_data_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [1:0]         ps_c;
  logic [29:0]        pc_in_c;
  logic               redirect;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    count_d      = count_q;
    ps_c         = 2'b00;
    pc_in_c      = '0;
    redirect     = (state_q != S_IDLE) && (bus.trap_req || bus.jump_req || bus.branch_req);

    // Redirects steer the PC on the same edge; lower-priority requests are dropped.
    if (state_q != S_IDLE) begin
      if (bus.trap_req) begin
        ps_c    = 2'b11;
        pc_in_c = TRAP_VECTOR;
      end else if (bus.jump_req) begin
        ps_c    = 2'b11;
        pc_in_c = bus.jump_target;
      end else if (bus.branch_req) begin
        ps_c    = 2'b10;
        pc_in_c = bus.branch_offset;
      end
    end

    unique case (state_q)
      S_IDLE: state_d = bus.halt_req ? S_HALT : S_FETCH;

      S_FETCH: begin
        if (bus.imem_ack) begin
          if (redirect) begin
            if (bus.halt_req) state_d = S_HALT;
          end else begin
            inst_data_d  = bus.imem_rdata;
            inst_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end else if (redirect) begin
          state_d = S_DRAIN;
        end
      end

      S_HOLD: begin
        if (bus.inst_ready) begin
          count_d      = count_q + COUNT_W'(1);
          inst_valid_d = 1'b0;
          if (redirect) begin
            state_d = S_FETCH;
          end else begin
            ps_c    = 2'b01;
            state_d = bus.halt_req ? S_HALT : S_FETCH;
          end
        end else if (redirect) begin
          inst_valid_d = 1'b0;
          state_d      = S_FETCH;
        end
      end

      // The stale request must complete before a new one may be issued.
      S_DRAIN: if (bus.imem_ack) state_d = S_FETCH;

      S_HALT: if (!bus.halt_req) state_d = S_FETCH;

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.PS         = ps_c;
  assign bus.pc_in      = pc_in_c;
  assign bus.imem_req   = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign bus.imem_addr  = bus.pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_data  = inst_data_q;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.inst_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: transaction-level model, PC register and
// instruction memory responder, with per-cycle comparison plus literal checks.
module tb_fetch_sequencer;
  localparam int unsigned CW = 4;
  localparam logic [29:0] TV = 30'h00000100;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_sequencer_if #(.COUNT_W(CW)) bus ();

  fetch_sequencer #(.TRAP_VECTOR(TV), .COUNT_W(CW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int ps01     = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: started / request outstanding / request stale / holding an instruction / halted.
  bit             m_started, m_out, m_stale, m_have, m_halted;
  logic [31:0]    m_inst;
  logic [CW-1:0]  m_count;
  logic [31:0]    pc;

  assign bus.pc_q = pc;

  function automatic bit m_redir();
    return m_started && (bus.trap_req || bus.jump_req || bus.branch_req);
  endfunction

  function automatic logic [1:0] exp_ps();
    if (m_redir()) return (bus.trap_req || bus.jump_req) ? 2'b11 : 2'b10;
    if (m_have && bus.inst_ready) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [29:0] exp_pcin();
    if (!m_redir()) return 30'h0;
    if (bus.trap_req) return TV;
    if (bus.jump_req) return bus.jump_target;
    return bus.branch_offset;
  endfunction

  always @(posedge clock or posedge reset) begin
    bit r;
    if (reset) begin
      m_started = 0; m_out = 0; m_stale = 0; m_have = 0; m_halted = 0;
      m_inst = '0; m_count = '0;
      pc <= '0;
    end else begin
      r = m_redir();
      case (exp_ps())
        2'b01:   pc <= pc + 32'd4;
        2'b10:   pc <= pc + 32'd4 + {bus.branch_offset, 2'b00};
        2'b11:   pc <= {2'b00, exp_pcin()};
        default: pc <= pc;
      endcase
      if (!m_started) begin
        m_started = 1;
        if (bus.halt_req) m_halted = 1;
        else begin m_out = 1; m_stale = 0; end
      end else if (m_halted) begin
        if (!bus.halt_req) begin m_halted = 0; m_out = 1; m_stale = 0; end
      end else if (m_have) begin
        if (bus.inst_ready || r) begin
          m_have = 0;
          if (bus.inst_ready) m_count++;
          if (bus.inst_ready && !r && bus.halt_req) m_halted = 1;
          else begin m_out = 1; m_stale = 0; end
        end
      end else if (m_out) begin
        if (bus.imem_ack) begin
          if (m_stale) m_stale = 0;
          else if (r) begin
            if (bus.halt_req) begin m_out = 0; m_halted = 1; end
          end else begin
            m_out = 0; m_have = 1; m_inst = bus.imem_rdata;
          end
        end else if (r) begin
          m_stale = 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("PS", bus.PS, exp_ps());
    chk("pc_in", bus.pc_in, exp_pcin());
    chk("imem_req", bus.imem_req, m_out);
    if (m_out && !m_stale) chk("imem_addr", bus.imem_addr, pc);
    chk("inst_valid", bus.inst_valid, m_have);
    chk("inst_data", bus.inst_data, m_inst);
    chk("halted", bus.halted, m_halted);
    chk("inst_count", bus.inst_count, m_count);
    if (bus.PS == 2'b01) ps01++;
  end

  // Instruction memory: one request at a time, ack after lat cycles.
  int          lat = 1;
  bit          use_ovr = 0;
  logic [31:0] ovr = '0;
  bit          pend = 0;
  int          cnt = 0;
  logic [31:0] raddr;
  logic [31:0] req_log[$];

  function automatic logic [31:0] data_for(input logic [31:0] a);
    return use_ovr ? ovr : (a ^ 32'h5A5A0000);
  endfunction

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      bus.imem_ack = 1'b0;
      if (reset) pend = 0;
      else begin
        if (!pend && bus.imem_req) begin
          pend = 1; cnt = lat; raddr = bus.imem_addr; req_log.push_back(raddr);
        end
        if (pend) begin
          if (cnt == 0) begin
            bus.imem_ack = 1'b1; bus.imem_rdata = data_for(raddr); pend = 0;
          end else cnt--;
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock); #1;
      bus.trap_req = 1'b0; bus.jump_req = 1'b0; bus.branch_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #3;
    reset = 1'b1;
    bus.trap_req = 0; bus.jump_req = 0; bus.branch_req = 0;
    bus.inst_ready = 0; bus.halt_req = 0;
    @(posedge clock); @(posedge clock); #3;
    req_log.delete();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int maxc);
    int n = 0;
    while (!bus.inst_valid && n < maxc) begin cyc(); n++; end
    chk("wait_valid", bus.inst_valid, 1'b1);
  endtask

  initial begin
    int p0, n0;
    bus.inst_ready = 0; bus.branch_req = 0; bus.branch_offset = '0;
    bus.jump_req = 0; bus.jump_target = '0; bus.trap_req = 0; bus.halt_req = 0;

    // 1: reset mid-FETCH, then a 2-cycle fetch of DEADBEEF and one accept
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    lat = 20;
    cyc(3);
    @(posedge clock); #3 reset = 1'b1;
    @(negedge clock);
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_PS", bus.PS, 0);
    chk("rst_inst_valid", bus.inst_valid, 0);
    chk("rst_inst_data", bus.inst_data, 0);
    chk("rst_count", bus.inst_count, 0);
    lat = 2; use_ovr = 1; ovr = 32'hDEADBEEF;
    @(posedge clock); #3 reset = 1'b0;
    cyc();
    chk("s1_fetch_req", bus.imem_req, 1);
    wait_valid(10);
    chk("s1_data", bus.inst_data, 32'hDEADBEEF);
    p0 = ps01;
    bus.inst_ready = 1;
    @(negedge clock);
    chk("s1_ps01", bus.PS, 2'b01);
    cyc(); bus.inst_ready = 0; cyc(2);
    @(negedge clock);
    chk("s1_ps01_once", ps01 - p0, 1);
    chk("s1_count", bus.inst_count, 1);
    use_ovr = 0;

    // 2: four sequential instructions, latency 1, decode always ready
    lat = 1; bus.inst_ready = 1;
    do_reset(); bus.inst_ready = 1;
    p0 = ps01;
    for (int i = 0; i < 40 && bus.inst_count != 4; i++) cyc();
    bus.inst_ready = 0;
    chk("s2_count", bus.inst_count, 4);
    chk("s2_ps01", ps01 - p0, 4);
    chk("s2_nreq", req_log.size() >= 4, 1);
    if (req_log.size() >= 4)
      for (int i = 0; i < 4; i++) chk("s2_addr", req_log[i], 32'(4 * i));

    // 3: backward branch taken together with an accept
    do_reset();
    cyc();
    wait_valid(10);
    bus.inst_ready = 1; bus.branch_req = 1; bus.branch_offset = 30'h3FFFFFFE;
    p0 = ps01;
    @(negedge clock);
    chk("s3_PS", bus.PS, 2'b10);
    chk("s3_pc_in", bus.pc_in, 30'h3FFFFFFE);
    cyc(); bus.inst_ready = 0;
    chk("s3_count", bus.inst_count, 1);
    chk("s3_pc", pc, 32'hFFFFFFFC);
    chk("s3_addr", bus.imem_addr, 32'hFFFFFFFC);
    @(negedge clock);
    chk("s3_no_ps01", ps01 - p0, 0);

    // 4: jump while a fetch is outstanding; stale response discarded
    lat = 3; use_ovr = 1; ovr = 32'h00001234;
    do_reset();
    cyc();
    bus.jump_req = 1; bus.jump_target = 30'h200;
    @(negedge clock);
    chk("s4_PS", bus.PS, 2'b11);
    chk("s4_pc_in", bus.pc_in, 30'h200);
    cyc();
    chk("s4_drain_req", bus.imem_req, 1);
    n0 = req_log.size();
    for (int i = 0; i < 10 && req_log.size() == n0; i++) begin
      cyc(); chk("s4_no_valid", bus.inst_valid, 0);
    end
    use_ovr = 0;
    chk("s4_newreq", req_log.size(), n0 + 1);
    chk("s4_addr", bus.imem_addr, 32'h200);
    wait_valid(10);
    chk("s4_data", bus.inst_data, 32'h5A5A0200);

    // 5: trap, jump and branch together; trap wins
    lat = 5;
    do_reset();
    cyc();
    bus.trap_req = 1; bus.jump_req = 1; bus.branch_req = 1;
    bus.jump_target = 30'h200; bus.branch_offset = 30'h5;
    @(negedge clock);
    chk("s5_PS", bus.PS, 2'b11);
    chk("s5_pc_in", bus.pc_in, 30'h100);
    cyc();
    chk("s5_pc", pc, 32'h100);
    wait_valid(30);
    chk("s5_data", bus.inst_data, 32'h5A5A0100);

    // 6: halt requested in HOLD, branch while halted, resume
    lat = 1;
    do_reset();
    cyc();
    wait_valid(10);
    bus.halt_req = 1;
    cyc();
    chk("s6_hold", bus.inst_valid, 1);
    bus.inst_ready = 1;
    cyc(); bus.inst_ready = 0;
    chk("s6_halted", bus.halted, 1);
    chk("s6_req", bus.imem_req, 0);
    chk("s6_valid", bus.inst_valid, 0);
    chk("s6_pc", pc, 32'h4);
    bus.branch_req = 1; bus.branch_offset = 30'h3;
    @(negedge clock);
    chk("s6_PS", bus.PS, 2'b10);
    cyc();
    chk("s6_still_halted", bus.halted, 1);
    chk("s6_pc_br", pc, 32'h14);
    bus.halt_req = 0;
    cyc();
    chk("s6_resumed", bus.halted, 0);
    chk("s6_req2", bus.imem_req, 1);
    chk("s6_addr", bus.imem_addr, 32'h14);

    // 7: counter wrap (17 accepts on a 4-bit counter)
    lat = 0;
    do_reset(); bus.inst_ready = 1;
    p0 = ps01;
    for (int i = 0; i < 150 && (ps01 - p0) < 17; i++) cyc();
    bus.inst_ready = 0;
    chk("s7_accepts", ps01 - p0, 17);
    chk("s7_wrap", bus.inst_count, 1);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM that sequences the program counter through instruction fetch. It drives the PC's 2-bit select (PS) and 30-bit operand (pc_in), and runs a single-outstanding request/ack handshake to instruction memory.
- Presents fetched instructions to decode over a valid/ready handshake.
- Arbitrates redirects (trap > jump > branch > sequential advance), supports halt/resume, and counts retired (accepted) instructions.

Parameters:
- TRAP_VECTOR, 30'h00000100, byte address loaded into the PC on trap (PS=11).
- COUNT_W, 32, width of the accepted-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_q  in  32  current PC value (PC register output Q).
- PS  out  2  PC select: 00 hold, 01 PC+4, 10 PC+4+4*pc_in, 11 load {2'b0,pc_in}.
- pc_in  out  30  PC operand: branch word offset or jump/trap byte address.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  fetch address; equals pc_q.
- imem_ack  in  1  response valid, one-cycle pulse.
- imem_rdata  in  32  fetched instruction.
- inst_valid  out  1  instruction available to decode.
- inst_data  out  32  registered instruction.
- inst_ready  in  1  decode accepts the instruction.
- branch_req  in  1  relative redirect, one-cycle pulse.
- branch_offset  in  30  two's-complement word offset.
- jump_req  in  1  absolute redirect, one-cycle pulse.
- jump_target  in  30  byte address.
- trap_req  in  1  trap redirect, one-cycle pulse.
- halt_req  in  1  level; request halt.
- halted  out  1  high in HALT.
- inst_count  out  COUNT_W  accepted-instruction count; wraps.

Behaviour:
- States: IDLE, FETCH, HOLD, DRAIN, HALT.
- Reset (asynchronous) forces:
  - state=IDLE, PS=00, pc_in=0, imem_req=0, inst_valid=0, inst_data=0, halted=0, inst_count=0.
- PS and pc_in are combinational (Mealy) from state and inputs, so the PC updates on the same edge as the triggering event.
- Default outputs: PS=00 and pc_in=0 unless a rule below applies.
- Redirect, evaluated every cycle in every state except IDLE, highest priority first:
  - trap_req: PS=11, pc_in=TRAP_VECTOR.
  - jump_req: PS=11, pc_in=jump_target.
  - branch_req: PS=10, pc_in=branch_offset.
  - Lower-priority simultaneous requests are dropped.
  - Any redirect clears inst_valid on the next edge (flush).
- IDLE:
  - imem_req=0.
  - Next state is FETCH, or HALT if halt_req.
  - Redirect inputs are ignored.
- FETCH:
  - imem_req=1, imem_addr=pc_q.
  - imem_ack with no redirect: inst_data<=imem_rdata, inst_valid<=1, go HOLD.
  - imem_ack with redirect in the same cycle: data discarded, stay FETCH; the next request uses the new PC.
  - Redirect without ack: go DRAIN. imem_req stays high until the outstanding ack arrives.
- HOLD:
  - inst_valid=1, imem_req=0.
  - inst_ready with no redirect: PS=01, inst_count+1, inst_valid<=0, go HALT if halt_req else FETCH.
  - inst_ready with a redirect: instruction is counted, redirect PS is used (no +4), go FETCH.
  - Redirect without inst_ready: flush, no count, go FETCH.
  - Otherwise: PS=00, hold.
- DRAIN:
  - imem_req=1 (same outstanding request); imem_addr is don't-care.
  - On imem_ack: discard data, go FETCH.
  - Further redirects are applied to the PC; stay DRAIN until ack.
- HALT:
  - halted=1, imem_req=0, inst_valid=0.
  - Redirects still update the PC; stay HALT.
  - halt_req low: go FETCH next cycle.
- halt_req in FETCH or DRAIN takes effect only after the current instruction is accepted, or from FETCH after a discarded ack.
- inst_count wraps from all-ones to 0.
- Branch arithmetic is owned by the PC (modulo 2^32). Negative offsets rely on zero-extension wrap, e.g. offset 30'h3FFFFFFF = -1 word.
- Never more than one outstanding imem request.
- imem_ack outside FETCH/DRAIN is ignored.

Test Plan:
- Reset mid-FETCH, release; imem_ack after 2 cycles with rdata=32'hDEADBEEF -> all outputs at reset values during reset; then IDLE->FETCH; inst_valid=1, inst_data=DEADBEEF; inst_ready -> PS=01 for exactly one cycle, inst_count=1.
- Sequential stream of 4 instructions, imem_ack latency 1, inst_ready always 1 -> PS=01 once per instruction, imem_addr follows pc_q 0,4,8,C, inst_count=4.
- branch_req with offset 30'h3FFFFFFE in HOLD with inst_ready=1 -> PS=10, pc_in=3FFFFFFE, inst_count increments, no PS=01, next fetch at PC-4.
- jump_req (target 30'h200) while FETCH request outstanding, ack 3 cycles later with rdata=1234 -> PS=11 on the request cycle, state DRAIN, response discarded (inst_valid stays 0), then FETCH at 0x200.
- trap_req, jump_req and branch_req in the same cycle -> PS=11, pc_in=TRAP_VECTOR (0x100); the others are dropped.
- halt_req=1 while in HOLD, then accept -> HALT, halted=1, imem_req=0; branch_req in HALT -> PS=10 that cycle, stays HALT; halt_req=0 -> FETCH next cycle.
